// File: rtl/cy_page_splitter.sv
// cy_page_splitter: cuts AXI4 bursts at page boundaries so the TLB downstream
// translates each sub-burst once, then merges the R/B responses per original burst.

// Small synchronous FIFO used to track sub-bursts in flight
module cy_ps_fifo #(
  parameter int W  = 1,
  parameter int LD = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic         o_full
);
  localparam int DEPTH = 2 ** LD;
  localparam logic [LD:0] DEPTH_CNT = DEPTH[LD:0];

  logic [W-1:0]  r_mem [DEPTH];
  logic [LD-1:0] r_wptr;
  logic [LD-1:0] r_rptr;
  logic [LD:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == DEPTH_CNT);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rptr];

  // Storage is left unreset; the pointers alone define which entries are live
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// Address-channel splitter shared by the AR and AW paths
module cy_ps_split #(
  parameter int PAGE_BITS = 12,
  parameter int BEAT_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_avalid,
  output logic        o_aready,
  input  logic [15:0] i_aid,
  input  logic [63:0] i_aaddr,
  input  logic [7:0]  i_alen,
  input  logic [2:0]  i_asize,
  input  logic        i_room,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [15:0] o_id,
  output logic [63:0] o_addr,
  output logic [7:0]  o_len,
  output logic [2:0]  o_size,
  output logic        o_fire,
  output logic        o_final
);
  localparam int SPAN = PAGE_BITS - BEAT_BITS;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_id;
  logic [63:0] r_addr;
  logic [2:0]  r_size;
  logic [8:0]  r_rem;
  logic [8:0]  w_bnd;
  logic [8:0]  w_n;
  logic        w_fire;

  // Beats left before the page edge; unsplit sizes take the whole remainder
  assign w_bnd   = 9'(1 << SPAN) - 9'(r_addr[PAGE_BITS-1:BEAT_BITS]);
  assign w_n     = ((r_size != 3'(BEAT_BITS)) || (r_rem < w_bnd)) ? r_rem : w_bnd;
  assign w_fire  = o_valid && i_ready;
  assign o_fire  = w_fire;
  assign o_final = (r_rem == w_n);
  assign o_id    = r_id;
  assign o_addr  = r_addr;
  assign o_len   = 8'(w_n - 9'd1);
  assign o_size  = r_size;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: accept one request, then issue until the remainder is gone
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_avalid) w_next = S_ISSUE;
      S_ISSUE: if (w_fire && o_final) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs: single-cycle accept in IDLE, throttled issue in ISSUE
  always_comb begin
    o_aready = 1'b0;
    o_valid  = 1'b0;
    case (r_state)
      S_IDLE:  o_aready = i_avalid;
      S_ISSUE: o_valid  = i_room;
      default: ;
    endcase
  end

  // Request latch and per-sub-burst address/remainder advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id   <= '0;
      r_addr <= '0;
      r_size <= '0;
      r_rem  <= '0;
    end else if (o_aready) begin
      r_id   <= i_aid;
      r_addr <= i_aaddr;
      r_size <= i_asize;
      r_rem  <= 9'(i_alen) + 9'd1;
    end else if (w_fire) begin
      r_addr <= ((r_addr >> BEAT_BITS) + 64'(w_n)) << BEAT_BITS;
      r_rem  <= r_rem - w_n;
    end
  end
endmodule

module cy_page_splitter #(
  parameter int PAGE_BITS = 12,
  parameter int BEAT_BITS = 6,
  parameter int FIFO_LD   = 6,
  parameter int USER_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_app_arvalid,
  output logic              o_app_arready,
  input  logic [15:0]       i_app_arid,
  input  logic [63:0]       i_app_araddr,
  input  logic [7:0]        i_app_arlen,
  input  logic [2:0]        i_app_arsize,
  output logic              o_app_rvalid,
  input  logic              i_app_rready,
  output logic [15:0]       o_app_rid,
  output logic [511:0]      o_app_rdata,
  output logic [1:0]        o_app_rresp,
  output logic              o_app_rlast,
  output logic [USER_W-1:0] o_app_ruser,
  input  logic              i_app_awvalid,
  output logic              o_app_awready,
  input  logic [15:0]       i_app_awid,
  input  logic [63:0]       i_app_awaddr,
  input  logic [7:0]        i_app_awlen,
  input  logic [2:0]        i_app_awsize,
  input  logic              i_app_wvalid,
  output logic              o_app_wready,
  input  logic [511:0]      i_app_wdata,
  input  logic [63:0]       i_app_wstrb,
  input  logic [USER_W-1:0] i_app_wuser,
  output logic              o_app_bvalid,
  input  logic              i_app_bready,
  output logic [15:0]       o_app_bid,
  output logic [1:0]        o_app_bresp,
  output logic              o_tlb_arvalid,
  input  logic              i_tlb_arready,
  output logic [15:0]       o_tlb_arid,
  output logic [63:0]       o_tlb_araddr,
  output logic [7:0]        o_tlb_arlen,
  output logic [2:0]        o_tlb_arsize,
  input  logic              i_tlb_rvalid,
  output logic              o_tlb_rready,
  input  logic [15:0]       i_tlb_rid,
  input  logic [511:0]      i_tlb_rdata,
  input  logic [1:0]        i_tlb_rresp,
  input  logic              i_tlb_rlast,
  input  logic [USER_W-1:0] i_tlb_ruser,
  output logic              o_tlb_awvalid,
  input  logic              i_tlb_awready,
  output logic [15:0]       o_tlb_awid,
  output logic [63:0]       o_tlb_awaddr,
  output logic [7:0]        o_tlb_awlen,
  output logic [2:0]        o_tlb_awsize,
  output logic              o_tlb_wvalid,
  input  logic              i_tlb_wready,
  output logic [511:0]      o_tlb_wdata,
  output logic [63:0]       o_tlb_wstrb,
  output logic              o_tlb_wlast,
  output logic [USER_W-1:0] o_tlb_wuser,
  input  logic              i_tlb_bvalid,
  output logic              o_tlb_bready,
  input  logic [15:0]       i_tlb_bid,
  input  logic [1:0]        i_tlb_bresp
);
  logic       w_ar_fire, w_ar_final, w_rt_head, w_rt_empty, w_rt_full;
  logic       w_aw_fire, w_aw_final, w_ws_empty, w_ws_full, w_wr_head, w_wr_empty, w_wr_full;
  logic [7:0] w_ws_head;
  logic [7:0] r_wcnt;
  logic       w_wbeat, w_wlast;
  logic [1:0] r_bacc;
  logic [1:0] w_bmax;
  logic       w_bfinal, w_bhs;

  cy_ps_split #(.PAGE_BITS(PAGE_BITS), .BEAT_BITS(BEAT_BITS)) u_ar (
    .clk(clk), .rst(rst),
    .i_avalid(i_app_arvalid), .o_aready(o_app_arready),
    .i_aid(i_app_arid), .i_aaddr(i_app_araddr), .i_alen(i_app_arlen), .i_asize(i_app_arsize),
    .i_room(!w_rt_full), .o_valid(o_tlb_arvalid), .i_ready(i_tlb_arready),
    .o_id(o_tlb_arid), .o_addr(o_tlb_araddr), .o_len(o_tlb_arlen), .o_size(o_tlb_arsize),
    .o_fire(w_ar_fire), .o_final(w_ar_final)
  );

  cy_ps_fifo #(.W(1), .LD(FIFO_LD)) u_rd_track (
    .clk(clk), .rst(rst), .i_push(w_ar_fire), .i_data(w_ar_final),
    .i_pop(i_tlb_rvalid && i_app_rready && i_tlb_rlast),
    .o_data(w_rt_head), .o_empty(w_rt_empty), .o_full(w_rt_full)
  );

  assign o_app_rvalid = i_tlb_rvalid;
  assign o_tlb_rready = i_app_rready;
  assign o_app_rid    = i_tlb_rid;
  assign o_app_rdata  = i_tlb_rdata;
  assign o_app_rresp  = i_tlb_rresp;
  assign o_app_ruser  = i_tlb_ruser;
  assign o_app_rlast  = i_tlb_rlast && w_rt_head && !w_rt_empty;

  cy_ps_split #(.PAGE_BITS(PAGE_BITS), .BEAT_BITS(BEAT_BITS)) u_aw (
    .clk(clk), .rst(rst),
    .i_avalid(i_app_awvalid), .o_aready(o_app_awready),
    .i_aid(i_app_awid), .i_aaddr(i_app_awaddr), .i_alen(i_app_awlen), .i_asize(i_app_awsize),
    .i_room(!w_ws_full && !w_wr_full), .o_valid(o_tlb_awvalid), .i_ready(i_tlb_awready),
    .o_id(o_tlb_awid), .o_addr(o_tlb_awaddr), .o_len(o_tlb_awlen), .o_size(o_tlb_awsize),
    .o_fire(w_aw_fire), .o_final(w_aw_final)
  );

  // The split FIFO holds each sub-burst's len so unsplit 256-beat bursts also fit
  cy_ps_fifo #(.W(8), .LD(FIFO_LD)) u_wr_split (
    .clk(clk), .rst(rst), .i_push(w_aw_fire), .i_data(o_tlb_awlen),
    .i_pop(w_wbeat && w_wlast),
    .o_data(w_ws_head), .o_empty(w_ws_empty), .o_full(w_ws_full)
  );

  cy_ps_fifo #(.W(1), .LD(FIFO_LD)) u_wr_resp (
    .clk(clk), .rst(rst), .i_push(w_aw_fire), .i_data(w_aw_final),
    .i_pop(w_bhs),
    .o_data(w_wr_head), .o_empty(w_wr_empty), .o_full(w_wr_full)
  );

  assign o_tlb_wvalid = i_app_wvalid && !w_ws_empty;
  assign o_app_wready = i_tlb_wready && !w_ws_empty;
  assign o_tlb_wdata  = i_app_wdata;
  assign o_tlb_wstrb  = i_app_wstrb;
  assign o_tlb_wuser  = i_app_wuser;
  assign w_wlast      = (r_wcnt == w_ws_head);
  assign o_tlb_wlast  = w_wlast;
  assign w_wbeat      = o_tlb_wvalid && i_tlb_wready;

  // Beat counter regenerates wlast at each sub-burst boundary
  always_ff @(posedge clk) begin
    if (rst)          r_wcnt <= '0;
    else if (w_wbeat) r_wcnt <= w_wlast ? 8'd0 : r_wcnt + 8'd1;
  end

  assign w_bfinal     = w_wr_head && !w_wr_empty;
  assign w_bmax       = (i_tlb_bresp > r_bacc) ? i_tlb_bresp : r_bacc;
  assign o_app_bvalid = i_tlb_bvalid && w_bfinal;
  assign o_app_bid    = i_tlb_bid;
  assign o_app_bresp  = w_bmax;
  assign o_tlb_bready = !w_wr_empty && (w_wr_head ? i_app_bready : 1'b1);
  assign w_bhs        = i_tlb_bvalid && o_tlb_bready;

  // Worst response seen across the non-final sub-bursts of the current write
  always_ff @(posedge clk) begin
    if (rst)        r_bacc <= 2'b00;
    else if (w_bhs) r_bacc <= w_bfinal ? 2'b00 : w_bmax;
  end
endmodule
